// File: rtl/localbus_xbar.sv
// Local-bus crossbar: one core-side master fanned out to NSLV base/mask windows.
// Slaves may insert wait states through a per-slave ack; a watchdog ends stalled
// accesses, and unmapped or timed-out accesses are reported with first-fault capture.
module localbus_xbar #(
  parameter int unsigned            XLEN       = 32,
  parameter int unsigned            NSLV       = 4,
  parameter logic [NSLV*XLEN-1:0]   SLV_BASE   = {32'h0003_0000, 32'h0002_0000,
                                                  32'h0001_0000, 32'h0000_0000},
  parameter logic [NSLV*XLEN-1:0]   SLV_MASK   = {4{32'hFFFF_0000}},
  parameter int unsigned            TMO_WIDTH  = 8,
  parameter int unsigned            TMO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_req,
  input  logic [XLEN-1:0]      m_addr,
  input  logic [XLEN-1:0]      m_wdata,
  input  logic [2:0]           m_we,
  output logic                 m_busy,
  output logic                 m_ready,
  output logic [XLEN-1:0]      m_rdata,
  output logic                 m_err,
  output logic [NSLV-1:0]      slv_sel,
  output logic [XLEN-1:0]      slv_addr,
  output logic [XLEN-1:0]      slv_wdata,
  output logic [2:0]           slv_we,
  input  logic [NSLV*XLEN-1:0] slv_rdata,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic                 err_clr,
  output logic [XLEN-1:0]      err_addr,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam bit                   TmoEn   = (TMO_CYCLES != 0);
  // Counter value seen in the last permitted ACCESS cycle.
  localparam logic [TMO_WIDTH-1:0] TmoLast = TMO_WIDTH'(TMO_CYCLES - 1);

  state_e                state_q;
  logic [NSLV-1:0]       sel_q;
  logic [XLEN-1:0]       addr_q, wdata_q, rdata_q;
  logic [2:0]            we_q;
  logic                  err_q;
  logic [TMO_WIDTH-1:0]  cnt_q;
  logic [XLEN-1:0]       err_addr_q, err_addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [NSLV-1:0]       dec_sel;
  logic                  dec_hit;
  logic                  ack_hit;
  logic [XLEN-1:0]       sel_rdata;
  logic                  tmo_hit;
  logic                  dec_err, tmo_err;

  // Address decode: first (lowest-index) matching window wins.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!dec_hit &&
          ((m_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN])) begin
        dec_sel[i] = 1'b1;
        dec_hit    = 1'b1;
      end
    end
  end

  // Honour only the selected slave's ack and read data.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | slv_rdata[i*XLEN +: XLEN];
    end
    ack_hit = |(slv_ack & sel_q);
    tmo_hit = TmoEn && (cnt_q == TmoLast);
    dec_err = (state_q == StIdle) && m_req && !dec_hit;
    tmo_err = (state_q == StAccess) && !ack_hit && tmo_hit;
  end

  // Transaction FSM with captured request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 3'b000;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (m_req) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            we_q    <= m_we;
            if (dec_hit) begin
              sel_q   <= dec_sel;
              state_q <= StAccess;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StAccess: begin
          if (ack_hit) begin
            rdata_q <= sel_rdata;
            err_q   <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= StResp;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Error status next state: clear beats a same-cycle error event.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end else if (dec_err || tmo_err) begin
      if (err_cnt_q == 8'd0) err_addr_d = dec_err ? m_addr : addr_q;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_busy    = (state_q != StIdle);
  assign m_ready   = (state_q == StResp);
  assign m_rdata   = m_ready ? rdata_q : '0;
  assign m_err     = m_ready & err_q;
  assign slv_sel   = sel_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_we    = (|sel_q) ? we_q : 3'b000;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/localbus_xbar.md
Name: localbus_xbar

Overview:
Parametrised successor to the fixed three-region local bus decoder. It connects one core-side local-bus master to NSLV slaves, each with a base/mask window set by parameters. It adds a per-slave ready/ack handshake so slaves may insert wait states, registered read data, a timeout watchdog, and decode-error reporting with fault capture. It sits between the core data port and RAM, GPIO, VGA and future peripherals.

Parameters:
XLEN, 32, data and address width.
NSLV, 4, number of slave windows (1..16).
SLV_BASE, {32'h0003_0000,32'h0002_0000,32'h0001_0000,32'h0000_0000}, packed bases; slave i is bits [i*XLEN +: XLEN].
SLV_MASK, {4{32'hFFFF_0000}}, packed masks, same layout; slave i matches when (addr & mask_i) == base_i.
TMO_WIDTH, 8, width of the wait-state counter.
TMO_CYCLES, 255, number of ACCESS cycles without ack before a timeout error; 0 disables the timeout.

Ports:
clk  in  1  global clock (all logic on its rising edge)
rst_n  in  1  global reset, asynchronous assert, active-low
m_req  in  1  master request; sampled only in IDLE
m_addr  in  XLEN  master address
m_wdata  in  XLEN  master write data
m_we  in  3  write enable (byte/half/word code); 3'b000 means read
m_busy  out  1  high whenever state != IDLE
m_ready  out  1  one-cycle response strobe
m_rdata  out  XLEN  read data; valid when m_ready=1
m_err  out  1  error flag; valid when m_ready=1
slv_sel  out  NSLV  one-hot slave select, registered
slv_addr  out  XLEN  captured address, broadcast to all slaves
slv_wdata  out  XLEN  captured write data, broadcast to all slaves
slv_we  out  3  captured m_we while any slv_sel bit is high, else 3'b000
slv_rdata  in  NSLV*XLEN  packed slave read data; slave i is bits [i*XLEN +: XLEN]
slv_ack  in  NSLV  per-slave completion; only the selected bit is honoured
err_clr  in  1  synchronous clear of the error status
err_addr  out  XLEN  address of the first unacknowledged error
err_cnt  out  8  error count, saturating at 255

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal address, write-data and write-enable captures cleared; timeout counter cleared. Reset asserted mid-transaction aborts it with no m_ready.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On m_req=1: capture m_addr, m_wdata and m_we.
  - Decode: the lowest-index matching slave wins on overlap.
  - Match found: next cycle is ACCESS with slv_sel[k]=1.
  - No match: go to RESP with the error flag set, and load the error status (below).
- ACCESS:
  - slv_sel, slv_addr, slv_wdata and slv_we are held stable.
  - slv_ack[k]=1: rdata_q <= slv_rdata[k] (also on writes); err_q=0; go to RESP; slv_sel clears the next cycle.
  - No ack: the counter increments. When it reaches TMO_CYCLES (and TMO_CYCLES != 0): rdata_q=0; err_q=1; load the error status; go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from unselected slaves are ignored.
- RESP: m_ready=1, m_rdata=rdata_q, m_err=err_q for exactly one cycle; then IDLE. The counter clears.
- m_req outside IDLE is ignored; there is no queueing, and the master must re-request.
- Latency: with ack in the first ACCESS cycle, m_req at cycle 0 gives m_ready at cycle 2. Each wait cycle adds 1. A decode error gives m_ready at cycle 1.
- Error status on each error: err_cnt increments, saturating at 255. err_addr loads only if err_cnt was 0 before the increment (first-fault capture).
- err_clr=1 clears err_cnt and err_addr. If an error event occurs in the same cycle, clear wins and the event is not counted.
- m_rdata=0 whenever m_ready=0.

Test Plan:
- Read slave 1: m_addr=32'h0001_0010, slave 1 acks in the first ACCESS cycle with 32'hDEAD_BEEF -> slv_sel=4'b0010 at cycle 1; m_ready, m_rdata=32'hDEAD_BEEF and m_err=0 at cycle 2.
- Write slave 2 with wait states: m_we=3'b100, m_wdata=32'h1234_5678, ack after 3 wait cycles -> slv_we=3'b100 held for 4 cycles; m_ready at cycle 5 with m_err=0; slv_we=0 afterwards.
- Unmapped address 32'h0005_0000 -> slv_sel stays 0; m_ready=1 and m_err=1 at cycle 1; err_addr=32'h0005_0000; err_cnt=1. A second unmapped access to 32'h0006_0000 -> err_cnt=2, err_addr unchanged. err_clr -> both return to 0.
- Timeout: TMO_CYCLES=4, slave 0 never acks -> slv_sel=4'b0001 for 4 cycles, then m_ready with m_err=1 and m_rdata=0. Variant: ack in the 4th cycle -> m_err=0.
- Overlap and ignored inputs: slave 0 mask 32'hFFFE_0000 overlapping slave 1, access to 32'h0001_0000 -> slv_sel=4'b0001. m_req pulses during ACCESS are ignored; a slv_ack from an unselected slave does not complete the transaction.
- Reset mid-ACCESS: rst_n pulsed low -> slv_sel, m_busy and m_ready go to 0 immediately (asynchronous). A new request after release completes normally.
